// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave RAM front end.
package spi_slave_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    localparam int RX_BITS = 10;
    localparam int TX_BITS = 8;

endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus the word/byte handshake toward the RAM controller.
interface spi_slave_if #(
    parameter int ADDR_SIZE = 10,
    parameter int TX_SIZE   = 8
);
    logic                 SS_n;
    logic                 MOSI;
    logic                 MISO;
    logic [ADDR_SIZE-1:0] rx_data;
    logic                 rx_valid;
    logic [TX_SIZE-1:0]   tx_data;
    logic                 tx_valid;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave.sv
// SPI slave: command bit selects the phase, 10-bit word deserialised to
// rx_data, RAM read byte serialised back on MISO MSB first.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int ADDR_SIZE = RX_BITS,
    parameter int TX_SIZE   = TX_BITS
) (
    input  logic         clk,
    input  logic         rst,
    spi_slave_if.slave   bus
);

    state_t                CS, NS;
    logic [3:0]            counter;
    logic [3:0]            tx_cnt;
    logic [ADDR_SIZE-1:0]  shift;
    logic [TX_SIZE-1:0]    tx_shift;
    logic                  tx_busy;
    logic                  tx_done;
    logic                  rd_addr_seen;
    logic                  miso_q;
    logic [ADDR_SIZE-1:0]  rx_data_q;
    logic                  rx_valid_q;

    assign bus.MISO     = miso_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

    always_comb begin
        NS = CS;
        if (bus.SS_n) begin
            NS = IDLE;
        end else begin
            case (CS)
                IDLE:    NS = CHK_CMD;
                CHK_CMD: begin
                    if (!bus.MOSI)        NS = WRITE;
                    else if (rd_addr_seen) NS = READ_DATA;
                    else                   NS = READ_ADD;
                end
                default: NS = CS;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            CS           <= IDLE;
            counter      <= '0;
            tx_cnt       <= '0;
            shift        <= '0;
            tx_shift     <= '0;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
            rd_addr_seen <= 1'b0;
            miso_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
        end else begin
            CS         <= NS;
            rx_valid_q <= 1'b0;
            if (bus.SS_n) begin
                // Frame ended or aborted: drop any partial word or byte.
                counter <= '0;
                tx_cnt  <= '0;
                tx_busy <= 1'b0;
                tx_done <= 1'b0;
                miso_q  <= 1'b0;
            end else if (CS == WRITE || CS == READ_ADD || CS == READ_DATA) begin
                if (counter != 4'(ADDR_SIZE)) begin
                    shift   <= {shift[ADDR_SIZE-2:0], bus.MOSI};
                    counter <= counter + 4'd1;
                    if (counter == 4'(ADDR_SIZE - 1)) begin
                        rx_data_q  <= {shift[ADDR_SIZE-2:0], bus.MOSI};
                        rx_valid_q <= 1'b1;
                        if (CS == READ_ADD)
                            rd_addr_seen <= 1'b1;
                    end
                end else if (CS == READ_DATA) begin
                    if (tx_busy) begin
                        if (tx_cnt == 4'(TX_SIZE)) begin
                            miso_q       <= 1'b0;
                            tx_busy      <= 1'b0;
                            tx_done      <= 1'b1;
                            rd_addr_seen <= 1'b0;
                        end else begin
                            miso_q   <= tx_shift[TX_SIZE-2];
                            tx_shift <= tx_shift << 1;
                            tx_cnt   <= tx_cnt + 4'd1;
                        end
                    end else if (!tx_done && bus.tx_valid) begin
                        // MSB goes out on the latch edge itself.
                        tx_shift <= bus.tx_data;
                        miso_q   <= bus.tx_data[TX_SIZE-1];
                        tx_cnt   <= 4'd1;
                        tx_busy  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: write/read frames, MISO readback, abort, reset mid-read.
module tb_spi_slave;
    import spi_slave_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    spi_slave_if #(.ADDR_SIZE(10), .TX_SIZE(8)) bus();

    spi_slave #(.ADDR_SIZE(10), .TX_SIZE(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives IDLE edge, command edge and 10 word bits; leaves SS_n low.
    task automatic frame(input logic cmd, input logic [9:0] word, input string tag);
        int pulses;
        logic [9:0] prev;
        pulses = 0;
        prev = bus.rx_data;
        bus.SS_n = 1'b0;
        bus.MOSI = cmd;
        step();
        step();
        for (int i = 9; i >= 0; i--) begin
            bus.MOSI = word[i];
            step();
            if (bus.rx_valid) pulses++;
            if (i == 5) chk({tag, "_nopartial"}, 32'(bus.rx_data), 32'(prev));
        end
        chk({tag, "_rxdata"}, 32'(bus.rx_data), 32'(word));
        bus.MOSI = ~bus.MOSI;
        step();
        if (bus.rx_valid) pulses++;
        chk({tag, "_pulses"}, 32'(pulses), 32'd1);
        chk({tag, "_hold"}, 32'(bus.rx_data), 32'(word));
    endtask

    task automatic end_frame(input string tag);
        bus.SS_n = 1'b1;
        step();
        chk({tag, "_idle"}, 32'(dut.CS), 32'(IDLE));
        chk({tag, "_miso0"}, 32'(bus.MISO), 32'd0);
    endtask

    initial begin
        logic [7:0] byte_v;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        bus.tx_data = 8'h00;
        bus.tx_valid = 1'b0;
        step();
        step();
        chk("rst_cs", 32'(dut.CS), 32'(IDLE));
        chk("rst_miso", 32'(bus.MISO), 32'd0);
        chk("rst_rxdata", 32'(bus.rx_data), 32'd0);
        chk("rst_rxvalid", 32'(bus.rx_valid), 32'd0);
        chk("rst_rdseen", 32'(dut.rd_addr_seen), 32'd0);
        rst = 1'b0;
        step();

        frame(1'b0, 10'h00A, "wr_addr");
        chk("wr_addr_state", 32'(dut.CS), 32'(WRITE));
        end_frame("wr_addr");

        frame(1'b0, 10'h16D, "wr_data");
        chk("wr_data_rdseen", 32'(dut.rd_addr_seen), 32'd0);
        end_frame("wr_data");

        frame(1'b1, 10'h22B, "rd_addr");
        chk("rd_addr_state", 32'(dut.CS), 32'(READ_ADD));
        chk("rd_addr_rdseen", 32'(dut.rd_addr_seen), 32'd1);
        end_frame("rd_addr");

        frame(1'b1, 10'h300, "rd_data");
        chk("rd_data_state", 32'(dut.CS), 32'(READ_DATA));
        chk("rd_data_idle_miso", 32'(bus.MISO), 32'd0);
        byte_v = 8'hBE;
        bus.tx_data = byte_v;
        bus.tx_valid = 1'b1;
        step();
        bus.tx_valid = 1'b0;
        bus.tx_data = 8'h00;
        chk("miso_b7", 32'(bus.MISO), 32'd1);
        for (int i = 6; i >= 0; i--) begin
            bus.tx_valid = (i == 3);
            step();
            chk($sformatf("miso_b%0d", i), 32'(bus.MISO), 32'(byte_v[i]));
        end
        bus.tx_valid = 1'b0;
        step();
        chk("miso_after", 32'(bus.MISO), 32'd0);
        chk("rd_done_rdseen", 32'(dut.rd_addr_seen), 32'd0);
        bus.tx_valid = 1'b1;
        bus.tx_data = 8'hFF;
        step();
        chk("miso_no_relatch", 32'(bus.MISO), 32'd0);
        bus.tx_valid = 1'b0;
        end_frame("rd_data");

        // Abort after 5 payload bits
        bus.SS_n = 1'b0;
        bus.MOSI = 1'b0;
        step();
        step();
        begin
            int pulses;
            logic [9:0] abort_word;
            pulses = 0;
            abort_word = 10'h1FF;
            for (int i = 9; i >= 5; i--) begin
                bus.MOSI = abort_word[i];
                step();
                if (bus.rx_valid) pulses++;
            end
            bus.SS_n = 1'b1;
            step();
            if (bus.rx_valid) pulses++;
            chk("abort_pulses", 32'(pulses), 32'd0);
        end
        chk("abort_idle", 32'(dut.CS), 32'(IDLE));
        chk("abort_rxdata", 32'(bus.rx_data), 32'h300);
        chk("abort_counter", 32'(dut.counter), 32'd0);

        frame(1'b0, 10'h1A5, "post_abort");
        end_frame("post_abort");

        // Reset during MISO shifting
        frame(1'b1, 10'h255, "rst_rdaddr");
        end_frame("rst_rdaddr");
        frame(1'b1, 10'h3C3, "rst_rddata");
        bus.tx_data = 8'hFF;
        bus.tx_valid = 1'b1;
        step();
        bus.tx_valid = 1'b0;
        step();
        step();
        chk("rst_mid_miso_hi", 32'(bus.MISO), 32'd1);
        rst = 1'b1;
        step();
        chk("rst_mid_miso", 32'(bus.MISO), 32'd0);
        chk("rst_mid_cs", 32'(dut.CS), 32'(IDLE));
        chk("rst_mid_rdseen", 32'(dut.rd_addr_seen), 32'd0);
        chk("rst_mid_rxdata", 32'(bus.rx_data), 32'd0);
        rst = 1'b0;
        bus.SS_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
